// File: rtl/tenyr_reset_seq_pkg.sv
// Shared definitions for the Tenyr reset/halt sequencer: halt bus layout
// and sequencer state encodings.
package tenyr_reset_seq_pkg;

    // Layout of the Tenyr core halt bus; the sequencer only owns HALT_SIM.
    localparam int HALTBUSWIDTH = 3;
    localparam int HALT_SIM     = 0;

    typedef enum logic [1:0] {
        S_HOLD   = 2'd0,
        S_PRE    = 2'd1,
        S_RUN    = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tenyr_reset_seq_watchdog.sv
// Watchdog for the Tenyr reset sequencer: counts running cycles, is cleared
// by kick, and flags expiry when WD_CYCLES-1 is reached without a kick.
// Only instantiated when TENYR_RESETSEQ_WATCHDOG_EN is defined.
module reset_watchdog #(
    parameter int WD_CYCLES = 1024,
    parameter int CNT_W     = 11
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic kick,
    output logic expire
);

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WD_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Expiry is decided in the same cycle the count hits its last value; a kick arriving then wins.
    always_comb begin
        expire = 1'b0;
        if (enable && !kick && (count == WD_LAST)) begin
            expire = 1'b1;
        end
    end

    // Counter only moves while the core runs, so it freezes during a debug halt.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (enable) begin
            if (kick || expire) begin
                count <= '0;
            end else if (count != '1) begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/tenyr_reset_seq.sv
// Reset/halt sequencer for the Tenyr core. Produces cpu_reset_n and the halt
// bus from a synchronous system reset, and offers a debug halt handshake.
// Define TENYR_RESETSEQ_WATCHDOG_EN to add a kick-driven watchdog that
// re-runs the reset sequence on expiry.
module tenyr_reset_seq
    import tenyr_reset_seq_pkg::*;
#(
    parameter int HALT_CYCLES  = 40,
    parameter int RESET_CYCLES = 50,
    parameter int WD_CYCLES    = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ext_halt_req,
    output logic                    ext_halt_ack,
    input  logic                    kick,
    output logic [HALTBUSWIDTH-1:0] halt,
    output logic                    cpu_reset_n,
    output logic                    running,
    output logic                    wd_timeout
);

    localparam int CNT_W = $clog2(max_int(RESET_CYCLES, WD_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] HALT_LAST  = CNT_W'(HALT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(RESET_CYCLES - 1);

    state_t                  state;
    state_t                  state_next;
    logic [CNT_W-1:0]        count;
    logic [CNT_W-1:0]        count_next;
    logic [HALTBUSWIDTH-1:0] halt_next;
    logic                    cpu_reset_n_next;
    logic                    ack_next;
    logic                    running_next;
    logic                    wd_expire;

`ifdef TENYR_RESETSEQ_WATCHDOG_EN
    reset_watchdog #(
        .WD_CYCLES (WD_CYCLES),
        .CNT_W     (CNT_W)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .enable (state == S_RUN),
        .kick   (kick),
        .expire (wd_expire)
    );
`else
    logic unused_kick;
    assign unused_kick = kick;
    assign wd_expire   = 1'b0;
`endif

    // Next state and counter; outputs are derived from the next state so they register in step with it.
    always_comb begin
        state_next       = state;
        count_next       = count;
        halt_next        = '0;
        cpu_reset_n_next = 1'b0;
        ack_next         = 1'b0;
        running_next     = 1'b0;

        case (state)
            S_HOLD: begin
                if (count != '1) begin
                    count_next = count + CNT_W'(1);
                end
                if (count == HALT_LAST) begin
                    state_next = S_PRE;
                end
            end
            S_PRE: begin
                if (count != '1) begin
                    count_next = count + CNT_W'(1);
                end
                if (count == RESET_LAST) begin
                    state_next = S_RUN;
                    count_next = '0;
                end
            end
            S_RUN: begin
                if (wd_expire) begin
                    state_next = S_HOLD;
                    count_next = '0;
                end else if (ext_halt_req) begin
                    state_next = S_HALTED;
                end
            end
            S_HALTED: begin
                if (!ext_halt_req) begin
                    state_next = S_RUN;
                end
            end
            default: begin
                state_next = S_HOLD;
                count_next = '0;
            end
        endcase

        halt_next[HALT_SIM] = (state_next == S_HOLD) || (state_next == S_HALTED);
        cpu_reset_n_next    = (state_next == S_RUN)  || (state_next == S_HALTED);
        ack_next            = (state_next == S_HALTED);
        running_next        = (state_next == S_RUN);
    end

    // State, counter and registered outputs; reset forces the held-in-reset values on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_HOLD;
            count        <= '0;
            halt         <= HALTBUSWIDTH'(1) << HALT_SIM;
            cpu_reset_n  <= 1'b0;
            ext_halt_ack <= 1'b0;
            running      <= 1'b0;
            wd_timeout   <= 1'b0;
        end else begin
            state        <= state_next;
            count        <= count_next;
            halt         <= halt_next;
            cpu_reset_n  <= cpu_reset_n_next;
            ext_halt_ack <= ack_next;
            running      <= running_next;
            wd_timeout   <= wd_expire;
        end
    end

endmodule

// File: tb/tb_tenyr_reset_seq.sv
// Directed self-checking bench for tenyr_reset_seq. Cycle numbers count
// rising edges since the first edge that samples reset low.
module tb_tenyr_reset_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ext_halt_req = 1'b0;
    logic       ext_halt_ack;
    logic       kick = 1'b0;
    logic [2:0] halt;
    logic       cpu_reset_n;
    logic       running;
    logic       wd_timeout;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    logic ack_without_halt = 1'b0;
    logic flag_a;
    logic flag_b;

    tenyr_reset_seq #(
        .HALT_CYCLES  (40),
        .RESET_CYCLES (50),
        .WD_CYCLES    (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ext_halt_req (ext_halt_req),
        .ext_halt_ack (ext_halt_ack),
        .kick         (kick),
        .halt         (halt),
        .cpu_reset_n  (cpu_reset_n),
        .running      (running),
        .wd_timeout   (wd_timeout)
    );

    // Free-running 10 ns board clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Drives inputs for the coming edge, then samples 1 ns after it.
    task automatic applyStimulus(input logic r, input logic req, input logic k);
        reset        = r;
        ext_halt_req = req;
        kick         = k;
        @(posedge clk);
        #1;
        cyc++;
        if (ext_halt_ack && !halt[0]) ack_without_halt = 1'b1;
    endtask

    task automatic runUntil(input int target, input logic req);
        while (cyc < target) applyStimulus(1'b0, req, 1'b0);
    endtask

    task automatic startSequence();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        cyc = 0;
    endtask

    initial begin
        // Power-on reset values and the 40/50 release timing.
        startSequence();
        checkOutput("rst_halt", 32'(halt), 32'h1);
        checkOutput("rst_cpu_reset_n", 32'(cpu_reset_n), 32'h0);
        checkOutput("rst_ack", 32'(ext_halt_ack), 32'h0);
        checkOutput("rst_running", 32'(running), 32'h0);
        checkOutput("rst_wd_timeout", 32'(wd_timeout), 32'h0);
        runUntil(39, 1'b0);
        checkOutput("c39_halt", 32'(halt), 32'h1);
        runUntil(40, 1'b0);
        checkOutput("c40_halt", 32'(halt), 32'h0);
        checkOutput("c40_cpu_reset_n", 32'(cpu_reset_n), 32'h0);
        checkOutput("c40_running", 32'(running), 32'h0);
        runUntil(49, 1'b0);
        checkOutput("c49_cpu_reset_n", 32'(cpu_reset_n), 32'h0);
        runUntil(50, 1'b0);
        checkOutput("c50_cpu_reset_n", 32'(cpu_reset_n), 32'h1);
        checkOutput("c50_running", 32'(running), 32'h1);
        checkOutput("c50_halt", 32'(halt), 32'h0);

        // Debug halt handshake: request at 60, drop at 70.
        runUntil(60, 1'b0);
        checkOutput("c60_halt", 32'(halt), 32'h0);
        runUntil(61, 1'b1);
        checkOutput("hs_halt", 32'(halt), 32'h1);
        checkOutput("hs_ack", 32'(ext_halt_ack), 32'h1);
        checkOutput("hs_running", 32'(running), 32'h0);
        checkOutput("hs_cpu_reset_n", 32'(cpu_reset_n), 32'h1);
        runUntil(70, 1'b1);
        checkOutput("hs_c70_halt", 32'(halt), 32'h1);
        runUntil(71, 1'b0);
        checkOutput("rel_halt", 32'(halt), 32'h0);
        checkOutput("rel_ack", 32'(ext_halt_ack), 32'h0);
        checkOutput("rel_running", 32'(running), 32'h1);

        // Reset pulsed mid-run at cycle 55.
        startSequence();
        runUntil(55, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("mid_halt", 32'(halt), 32'h1);
        checkOutput("mid_cpu_reset_n", 32'(cpu_reset_n), 32'h0);
        checkOutput("mid_ack", 32'(ext_halt_ack), 32'h0);
        checkOutput("mid_running", 32'(running), 32'h0);
        cyc = 0;

        // Restarted sequence with an early halt request from cycle 10.
        runUntil(10, 1'b0);
        flag_a = 1'b0;
        flag_b = 1'b0;
        while (cyc < 50) begin
            if (ext_halt_ack) flag_a = 1'b1;
            if (cyc >= 40 && halt[0]) flag_b = 1'b1;
            applyStimulus(1'b0, 1'b1, 1'b0);
        end
        checkOutput("early_no_ack", 32'(flag_a), 32'h0);
        checkOutput("early_halt_low_40_49", 32'(flag_b), 32'h0);
        checkOutput("early_c50_halt", 32'(halt), 32'h0);
        checkOutput("early_c50_ack", 32'(ext_halt_ack), 32'h0);
        checkOutput("early_c50_cpu_reset_n", 32'(cpu_reset_n), 32'h1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("early_c51_halt", 32'(halt), 32'h1);
        checkOutput("early_c51_ack", 32'(ext_halt_ack), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("early_c52_running", 32'(running), 32'h1);
        checkOutput("early_c52_ack", 32'(ext_halt_ack), 32'h0);

`ifdef TENYR_RESETSEQ_WATCHDOG_EN
        // Watchdog without kicks expires at cycle 66, then re-sequences.
        startSequence();
        runUntil(65, 1'b0);
        checkOutput("wd_c65_timeout", 32'(wd_timeout), 32'h0);
        checkOutput("wd_c65_cpu_reset_n", 32'(cpu_reset_n), 32'h1);
        runUntil(66, 1'b0);
        checkOutput("wd_c66_timeout", 32'(wd_timeout), 32'h1);
        checkOutput("wd_c66_cpu_reset_n", 32'(cpu_reset_n), 32'h0);
        checkOutput("wd_c66_halt", 32'(halt), 32'h1);
        runUntil(67, 1'b0);
        checkOutput("wd_c67_timeout", 32'(wd_timeout), 32'h0);
        runUntil(115, 1'b0);
        checkOutput("wd_c115_cpu_reset_n", 32'(cpu_reset_n), 32'h0);
        runUntil(116, 1'b0);
        checkOutput("wd_c116_cpu_reset_n", 32'(cpu_reset_n), 32'h1);

        // Kicks every 10 cycles keep the core running.
        flag_a = 1'b0;
        flag_b = 1'b0;
        while (cyc < 226) begin
            applyStimulus(1'b0, 1'b0, (cyc % 10) == 0);
            if (wd_timeout) flag_a = 1'b1;
            if (!running) flag_b = 1'b1;
        end
        checkOutput("wd_kick_no_timeout", 32'(flag_a), 32'h0);
        checkOutput("wd_kick_stays_running", 32'(flag_b), 32'h0);
`else
        // Without the watchdog, random kicks do nothing and the core keeps running.
        flag_a = 1'b0;
        flag_b = 1'b0;
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)));
            if (wd_timeout) flag_a = 1'b1;
            if (!running) flag_b = 1'b1;
        end
        checkOutput("nowd_no_timeout", 32'(flag_a), 32'h0);
        checkOutput("nowd_stays_running", 32'(flag_b), 32'h0);
        checkOutput("nowd_cpu_reset_n", 32'(cpu_reset_n), 32'h1);
`endif

        checkOutput("ack_implies_halt", 32'(ack_without_halt), 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
